// File: rtl/pulse_pkg.sv
// ============================================================================
// Module : pulse_pkg
// Brief  : Shared FSM state encoding and sample classification for pulse_meter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_F = 2'd1,
    DIV_D = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A sample is "high" only when strictly positive; zero counts as low.
  function automatic logic classify_hi(input logic sign_bit, input logic nonzero);
    return !sign_bit && nonzero;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frac_div.sv
// ============================================================================
// Module : frac_div
// Brief  : Fractional restoring divider, q = floor(num * 2^N / den), num < den
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frac_div #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] num,
  input  logic [N-1:0] den,
  output logic [N-1:0] q,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  den_q, den_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N:0]    rem_x2;
  logic          ge;

  always_comb begin
    // Remainder stays below den, so doubling never overflows N+1 bits.
    rem_x2 = rem_q << 1;
    ge     = (rem_x2 >= {1'b0, den_q});
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      rem_d = ge ? (rem_x2 - {1'b0, den_q}) : rem_x2;
      quo_d = {quo_q[N-2:0], ge};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      rem_d  = {1'b0, num};
      den_d  = den;
      quo_d  = '0;
      cnt_d  = CW'(N);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign q    = quo_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/pulse_meter.sv
// ============================================================================
// Module : pulse_meter
// Brief  : Recovers frequency and duty control words from a sampled pulse wave
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_meter
  import pulse_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] value,
  output logic [N-1:0] ctrl,
  output logic [N-1:0] duty,
  output logic         upd,
  output logic         locked
);

  state_e       state_q, state_d;
  logic         prev_hi_q, prev_hi_d;
  logic [N-1:0] per_cnt_q, per_cnt_d;
  logic [N-1:0] hi_cnt_q, hi_cnt_d;
  logic         armed_q, armed_d;
  logic [N-1:0] p_q, p_d;
  logic [N-1:0] h_q, h_d;
  logic [N-1:0] qf_q, qf_d;
  logic [N-1:0] ctrl_q, ctrl_d;
  logic [N-1:0] duty_q, duty_d;
  logic         locked_q, locked_d;
  logic         kick_q, kick_d;

  logic         hi, rise, loss, take;
  logic         div_start, div_done;
  logic [N-1:0] div_num, div_q;

  assign hi   = classify_hi(value[M-1], |value);
  assign rise = hi && !prev_hi_q;
  assign loss = &per_cnt_q;
  assign take = rise && armed_q && !loss && (state_q == IDLE);

  frac_div #(.N(N)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (p_q),
    .q     (div_q),
    .done  (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take)     state_d = DIV_F;
      DIV_F:   if (div_done) state_d = DIV_D;
      DIV_D:   if (div_done) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // kick_q starts 1/P one cycle after latching; H/P chains directly off its done.
  always_comb begin
    upd       = (state_q == DONE);
    div_start = kick_q || ((state_q == DIV_F) && div_done);
    div_num   = kick_q ? N'(1) : h_q;
  end

  always_comb begin
    prev_hi_d = hi;
    armed_d   = rise || (armed_q && !loss);
    kick_d    = take;
    p_d       = take ? per_cnt_q : p_q;
    h_d       = take ? hi_cnt_q : h_q;
    qf_d      = ((state_q == DIV_F) && div_done) ? div_q : qf_q;
    ctrl_d    = ctrl_q;
    duty_d    = duty_q;
    locked_d  = locked_q;
    if ((state_q == DIV_D) && div_done) begin
      ctrl_d   = qf_q;
      duty_d   = div_q;
      locked_d = 1'b1;
    end
    if (loss) locked_d = 1'b0;
    if (rise) begin
      per_cnt_d = N'(1);
      hi_cnt_d  = N'(1);
    end else begin
      per_cnt_d = loss ? per_cnt_q : per_cnt_q + N'(1);
      hi_cnt_d  = (hi && !(&hi_cnt_q)) ? hi_cnt_q + N'(1) : hi_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_hi_q <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      armed_q   <= 1'b0;
      p_q       <= '0;
      h_q       <= '0;
      qf_q      <= '0;
      ctrl_q    <= '0;
      duty_q    <= '0;
      locked_q  <= 1'b0;
      kick_q    <= 1'b0;
    end else begin
      prev_hi_q <= prev_hi_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      armed_q   <= armed_d;
      p_q       <= p_d;
      h_q       <= h_d;
      qf_q      <= qf_d;
      ctrl_q    <= ctrl_d;
      duty_q    <= duty_d;
      locked_q  <= locked_d;
      kick_q    <= kick_d;
    end
  end

  assign ctrl   = ctrl_q;
  assign duty   = duty_q;
  assign locked = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_meter.sv
// ============================================================================
// Module : tb_pulse_meter
// Brief  : Scoreboard bench for pulse_meter with a cycle-level reference model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_meter;

  localparam int N = 16;
  localparam int M = 16;
  localparam int LAT = 2 * N + 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [M-1:0] value = '0;
  logic [N-1:0]        ctrl, duty;
  logic                upd, locked;

  pulse_meter #(.N(N), .M(M)) dut (
    .clk    (clk),
    .rst    (rst),
    .value  (value),
    .ctrl   (ctrl),
    .duty   (duty),
    .upd    (upd),
    .locked (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  cyc;
    logic [N-1:0] ctrl;
    logic [N-1:0] duty;
  } exp_t;

  exp_t         sb[$];
  int unsigned  cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_upd = 0;
  logic [N-1:0] last_ctrl = '0, last_duty = '0;
  bit           spacing_on = 0, spacing_valid = 0;
  int unsigned  last_upd_cyc = 0;

  // reference model state
  logic [N-1:0] m_per = '0, m_hi = '0;
  logic         m_prev = 1'b0, m_armed = 1'b0;
  int unsigned  m_busy_until = 0, m_last_take = 0;
  bit           m_took = 0;
  logic         m_h, m_rise, m_loss;
  exp_t         m_e, mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_per = '0; m_hi = '0; m_prev = 1'b0; m_armed = 1'b0;
      m_busy_until = 0;
      sb.delete();
    end else begin
      m_h    = (value > 0);
      m_rise = m_h && !m_prev;
      m_loss = (m_per == {N{1'b1}});
      if (m_rise && m_armed && !m_loss && cyc >= m_busy_until) begin
        m_e.cyc  = cyc + LAT;
        m_e.ctrl = N'(32'h0001_0000 / 32'(m_per));
        m_e.duty = N'((32'(m_hi) << 16) / 32'(m_per));
        sb.push_back(m_e);
        m_busy_until = cyc + LAT + 2;
        m_took = 1;
        m_last_take = cyc;
      end
      m_armed = m_rise || (m_armed && !m_loss);
      if (m_rise) begin
        m_per = 1; m_hi = 1;
      end else begin
        if (m_per != {N{1'b1}}) m_per = m_per + 1'b1;
        if (m_h && m_hi != {N{1'b1}}) m_hi = m_hi + 1'b1;
      end
      m_prev = m_h;
    end
  end

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("upd_missing", 32'(0), 32'(1));
      void'(sb.pop_front());
    end
    if (upd) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        check("upd_ctrl", 32'(ctrl), 32'(mon_e.ctrl));
        check("upd_duty", 32'(duty), 32'(mon_e.duty));
        check("upd_locked", 32'(locked), 32'(1));
        last_ctrl = mon_e.ctrl;
        last_duty = mon_e.duty;
        n_upd++;
        if (spacing_on && spacing_valid) begin
          check("spacing_mod4", 32'((cyc - last_upd_cyc) % 4), 32'(0));
          check("spacing_min", 32'((cyc - last_upd_cyc) >= LAT), 32'(1));
        end
        spacing_valid = 1;
        last_upd_cyc  = cyc;
      end else begin
        check("upd_unexpected", 32'(1), 32'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit h);
    if (h)                          value = M'($urandom_range(1, 32767));
    else if ($urandom_range(0, 1)) value = '0;
    else                            value = M'($urandom_range(32768, 65535));
    tick();
  endtask

  task automatic train(input int period, input int high, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < period; i++)
        sample(i < high);
  endtask

  int n0;
  bit hit;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ctrl", 32'(ctrl), 32'(0));
    check("rst_duty", 32'(duty), 32'(0));
    check("rst_upd", 32'(upd), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
    rst = 1'b0;

    // negative and zero only: never arms, never updates
    repeat (120) sample(1'b0);
    check("t6_no_upd", 32'(n_upd), 32'(0));
    check("t6_locked", 32'(locked), 32'(0));

    train(8, 4, 12);
    check("t1_ctrl", 32'(ctrl), 32'h2000);
    check("t1_duty", 32'(duty), 32'h8000);
    check("t1_locked", 32'(locked), 32'(1));

    n0 = n_upd;
    train(10, 3, 12);
    repeat (40) sample(1'b0);
    check("t2_ctrl", 32'(ctrl), 32'h1999);
    check("t2_duty", 32'(duty), 32'h4CCC);
    check("t2_reupd", 32'((n_upd - n0) >= 2), 32'(1));

    value = 16'sh7FFF;
    repeat (100) tick();
    n0 = n_upd;
    repeat (65460) tick();
    check("t3_no_upd", 32'(n_upd), 32'(n0));
    check("t3_locked", 32'(locked), 32'(0));
    check("t3_ctrl_hold", 32'(ctrl), 32'(last_ctrl));
    check("t3_duty_hold", 32'(duty), 32'(last_duty));
    n0 = n_upd;
    train(10, 3, 8);
    repeat (40) sample(1'b0);
    check("t3_relock", 32'(locked), 32'(1));
    check("t3_new_upd", 32'((n_upd - n0) >= 1), 32'(1));

    spacing_on = 1; spacing_valid = 0;
    n0 = n_upd;
    train(4, 2, 30);
    repeat (40) sample(1'b0);
    spacing_on = 0;
    check("t4_upds", 32'((n_upd - n0) >= 2), 32'(1));
    check("t4_ctrl", 32'(ctrl), 32'h4000);
    check("t4_duty", 32'(duty), 32'h8000);

    m_took = 0;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      sample((i % 8) < 4);
      if (m_took && cyc >= m_last_take + 20) begin
        hit = 1;
        break;
      end
    end
    check("t5_reached_div", 32'(hit), 32'(1));
    rst = 1'b1;
    tick();
    check("t5_ctrl", 32'(ctrl), 32'(0));
    check("t5_duty", 32'(duty), 32'(0));
    check("t5_locked", 32'(locked), 32'(0));
    check("t5_upd", 32'(upd), 32'(0));
    rst = 1'b0;
    train(8, 4, 10);
    repeat (40) sample(1'b0);
    check("t5_relock", 32'(locked), 32'(1));
    check("t5_ctrl2", 32'(ctrl), 32'h2000);
    check("t5_duty2", 32'(duty), 32'h8000);

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
